load_resp_formatter: RTL and testbench

//  Sits downstream of the memory unit, between the DCACHE response port and writeback.

---
 rtl/load_resp_formatter.sv | 111 +++++++++++
 tb/tb_load_resp_formatter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/load_resp_formatter.sv
// load_resp_formatter: tracks one outstanding load/AMO, formats its DCACHE response
// and holds the result until writeback accepts it.
module load_resp_formatter #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 40,
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 200
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              kill_i,
   input  logic              req_fire_i,
   input  logic              req_load_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [2:0]        req_addr_lo_i,
   input  logic [4:0]        req_rd_i,
   input  logic [ADDR_W-1:0] req_pc_i,
   input  logic              resp_valid_i,
   input  logic              resp_nack_i,
   input  logic [DATA_W-1:0] resp_data_i,
   input  logic              wb_ready_i,
   output logic              wb_valid_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [4:0]        wb_rd_o,
   output logic [ADDR_W-1:0] wb_pc_o,
   output logic              busy_o,
   output logic              timeout_o
);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_e;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
   state_e              state_q, state_d;
   logic [2:0]          f3_q, f3_d, lo_q, lo_d;
   logic [4:0]          rd_q, rd_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [TMO_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d, sh, fmt;
   logic                tmo;
   always_comb begin
      sh  = resp_data_i >> {lo_q, 3'b000};
      fmt = (f3_q == 3'b000) ? {{(DATA_W-8){sh[7]}}, sh[7:0]} :
            (f3_q == 3'b100) ? {{(DATA_W-8){1'b0}}, sh[7:0]} :
            (f3_q == 3'b001) ? {{(DATA_W-16){sh[15]}}, sh[15:0]} :
            (f3_q == 3'b101) ? {{(DATA_W-16){1'b0}}, sh[15:0]} :
            (f3_q == 3'b010) ? {{(DATA_W-32){sh[31]}}, sh[31:0]} :
            (f3_q == 3'b110) ? {{(DATA_W-32){1'b0}}, sh[31:0]} :
            (f3_q == 3'b011) ? resp_data_i : '0;
      tmo       = cnt_q == TMO_LAST;
      state_d   = state_q;
      f3_d      = f3_q;
      lo_d      = lo_q;
      rd_d      = rd_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      timeout_o = 1'b0;
      case (state_q)
         IDLE: if (req_fire_i && req_load_i && !kill_i) begin
            state_d = WAIT;
            f3_d    = req_funct3_i;
            lo_d    = req_addr_lo_i;
            rd_d    = req_rd_i;
            pc_d    = req_pc_i;
            cnt_d   = '0;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // a nacked request has nothing left in flight, so a kill need not drain it
            if (kill_i) state_d = (resp_valid_i || resp_nack_i) ? IDLE : DRAIN;
            else if (resp_valid_i) begin
               state_d = HOLD;
               data_d  = fmt;
            end
            else if (resp_nack_i) state_d = IDLE;
            else if (tmo) begin
               state_d   = IDLE;
               timeout_o = 1'b1;
            end
         end
         HOLD: if (kill_i || wb_ready_i) state_d = IDLE;
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            if (resp_valid_i || resp_nack_i || tmo) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         f3_q    <= '0;
         lo_q    <= '0;
         rd_q    <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         lo_q    <= lo_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end
   assign wb_valid_o = state_q == HOLD;
   assign busy_o     = state_q != IDLE;
   assign wb_data_o  = data_q;
   assign wb_rd_o    = rd_q;
   assign wb_pc_o    = pc_q;
endmodule

// File: tb/tb_load_resp_formatter.sv
// tb_load_resp_formatter: directed checks of formatting, hold, kill, nack, timeout and reset.
module tb_load_resp_formatter;
   localparam int DATA_W = 64, ADDR_W = 40, TMO_W = 8, TMO_CYC = 200;
   logic              clk_i = 0, rstn_i = 0, kill_i = 0, req_fire_i = 0, req_load_i = 0;
   logic [2:0]        req_funct3_i = 0, req_addr_lo_i = 0;
   logic [4:0]        req_rd_i = 0;
   logic [ADDR_W-1:0] req_pc_i = 0;
   logic              resp_valid_i = 0, resp_nack_i = 0, wb_ready_i = 0;
   logic [DATA_W-1:0] resp_data_i = 0;
   logic              wb_valid_o, busy_o, timeout_o;
   logic [DATA_W-1:0] wb_data_o;
   logic [4:0]        wb_rd_o;
   logic [ADDR_W-1:0] wb_pc_o;
   int checks = 0, failures = 0;

   load_resp_formatter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .kill_i(kill_i), .req_fire_i(req_fire_i),
      .req_load_i(req_load_i), .req_funct3_i(req_funct3_i), .req_addr_lo_i(req_addr_lo_i),
      .req_rd_i(req_rd_i), .req_pc_i(req_pc_i), .resp_valid_i(resp_valid_i),
      .resp_nack_i(resp_nack_i), .resp_data_i(resp_data_i), .wb_ready_i(wb_ready_i),
      .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_pc_o(wb_pc_o),
      .busy_o(busy_o), .timeout_o(timeout_o));

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // fire, respond in the first WAIT cycle; returns in the first HOLD cycle
   task automatic do_load(input logic [2:0] f3, input logic [2:0] lo, input logic [4:0] rd,
                          input logic [ADDR_W-1:0] pc, input logic [63:0] data);
      req_fire_i = 1; req_load_i = 1; req_funct3_i = f3; req_addr_lo_i = lo;
      req_rd_i = rd; req_pc_i = pc;
      step();
      req_fire_i = 0;
      chk("valid_in_wait", wb_valid_o, 0);
      resp_valid_i = 1; resp_data_i = data;
      step();
      resp_valid_i = 0;
   endtask

   task automatic retire();
      wb_ready_i = 1;
      step();
      wb_ready_i = 0;
   endtask

   initial begin
      int early;
      #3;
      chk("rst_valid", wb_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_tmo", timeout_o, 0);
      chk("rst_data", wb_data_o, 0);
      chk("rst_rd", wb_rd_o, 0);
      chk("rst_pc", wb_pc_o, 0);
      step();
      rstn_i = 1;
      step();

      do_load(3'b000, 3'd3, 5'd5, 40'h1000, 64'h0000_0000_8000_0000);
      chk("lb_valid", wb_valid_o, 1);
      chk("lb_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_rd", wb_rd_o, 5);
      chk("lb_pc", wb_pc_o, 40'h1000);
      retire();
      chk("lb_idle_valid", wb_valid_o, 0);
      chk("lb_idle_busy", busy_o, 0);

      do_load(3'b110, 3'd4, 5'd6, 40'h1004, 64'h89AB_CDEF_0000_0000);
      chk("lwu_data", wb_data_o, 64'h0000_0000_89AB_CDEF);
      retire();
      do_load(3'b001, 3'd2, 5'd6, 40'h1008, 64'h0000_0000_ABCD_0000);
      chk("lh_data", wb_data_o, 64'hFFFF_FFFF_FFFF_ABCD);
      retire();
      do_load(3'b101, 3'd2, 5'd6, 40'h100C, 64'h0000_0000_ABCD_0000);
      chk("lhu_data", wb_data_o, 64'h0000_0000_0000_ABCD);
      retire();
      do_load(3'b010, 3'd0, 5'd6, 40'h1010, 64'h0000_0000_8000_0001);
      chk("lw_data", wb_data_o, 64'hFFFF_FFFF_8000_0001);
      retire();
      do_load(3'b001, 3'd7, 5'd6, 40'h1014, 64'hFF00_0000_0000_0000);
      chk("lh_misaligned", wb_data_o, 64'h0000_0000_0000_00FF);
      retire();
      do_load(3'b111, 3'd0, 5'd6, 40'h1018, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("f3_111_zero", wb_data_o, 0);
      retire();

      do_load(3'b011, 3'd5, 5'd9, 40'h2000, 64'h0123_4567_89AB_CDEF);
      req_fire_i = 1; req_rd_i = 5'd31; req_pc_i = 40'h3000;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", wb_valid_o, 1);
         chk("hold_data", wb_data_o, 64'h0123_4567_89AB_CDEF);
         chk("hold_rd", wb_rd_o, 9);
         chk("hold_pc", wb_pc_o, 40'h2000);
         step();
      end
      req_fire_i = 0;
      retire();
      chk("hold_exit_busy", busy_o, 0);
      chk("hold_exit_valid", wb_valid_o, 0);

      req_fire_i = 1; req_funct3_i = 3'b011; req_rd_i = 5'd10;
      step();
      req_fire_i = 0;
      step();
      kill_i = 1;
      step();
      kill_i = 0;
      for (int i = 0; i < 3; i++) begin
         chk("drain_busy", busy_o, 1);
         chk("drain_valid", wb_valid_o, 0);
         step();
      end
      resp_valid_i = 1; resp_data_i = 64'h55;
      chk("drain_resp_busy", busy_o, 1);
      step();
      resp_valid_i = 0;
      chk("drain_exit_busy", busy_o, 0);
      chk("drain_exit_valid", wb_valid_o, 0);

      req_fire_i = 1; req_funct3_i = 3'b000; req_addr_lo_i = 0; req_rd_i = 5'd7;
      step();
      req_fire_i = 0;
      resp_nack_i = 1;
      step();
      resp_nack_i = 0;
      chk("nack_busy", busy_o, 0);
      chk("nack_valid", wb_valid_o, 0);
      do_load(3'b000, 3'd0, 5'd7, 40'h4000, 64'h7F);
      chk("refire_data", wb_data_o, 64'h7F);
      chk("refire_rd", wb_rd_o, 7);
      retire();

      do_load(3'b011, 3'd0, 5'd3, 40'h4100, 64'h1);
      kill_i = 1; wb_ready_i = 1;
      step();
      kill_i = 0; wb_ready_i = 0;
      chk("kill_hold_valid", wb_valid_o, 0);

      req_fire_i = 1;
      step();
      req_fire_i = 0;
      kill_i = 1; resp_valid_i = 1;
      step();
      kill_i = 0; resp_valid_i = 0;
      chk("kill_resp_busy", busy_o, 0);
      chk("kill_resp_valid", wb_valid_o, 0);

      req_fire_i = 1;
      step();
      req_fire_i = 0;
      early = 0;
      for (int c = 1; c < TMO_CYC; c++) begin
         if (timeout_o !== 1'b0 || busy_o !== 1'b1) early++;
         step();
      end
      chk("tmo_early", early, 0);
      chk("tmo_pulse", timeout_o, 1);
      step();
      chk("tmo_busy_after", busy_o, 0);
      chk("tmo_pulse_end", timeout_o, 0);

      do_load(3'b011, 3'd0, 5'd4, 40'h5000, 64'hDEAD);
      chk("pre_rst_valid", wb_valid_o, 1);
      #2 rstn_i = 0;
      #1;
      chk("async_rst_valid", wb_valid_o, 0);
      chk("async_rst_data", wb_data_o, 0);
      step();
      rstn_i = 1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
